// File: rtl/jstepper.sv
// Book-clock instruction stepper: 4-phase book cycle, one-hot step ring, enable/set/done decode.
// Latency: decode is combinational from registers; step advances on the phase-3 edge, done in phase 3 of the last step.
// Backpressure: none; the optional halt (JSTEPPER_HALT_EN) freezes at the next book-cycle boundary.
module jstepper #(
    parameter int NSTEPS = 6
) (
    input  logic              clk,
    input  logic              reset,
`ifdef JSTEPPER_HALT_EN
    input  logic              halt,
`endif
    output logic              clke,
    output logic              clks,
    output logic [NSTEPS-1:0] step,
    output logic [1:0]        phase,
    output logic              done
);

    logic [1:0]        phase_q, phase_nxt;
    logic [NSTEPS-1:0] step_q, step_nxt;
    // armed is low during reset and for nothing else; it keeps every decode
    // dark while reset is held even though phase sits at 0.
    logic              armed;
    logic              run_active;

`ifdef JSTEPPER_HALT_EN
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state_q, state_nxt;

    // State register for the RUN/HALTED machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Halt only takes effect on the phase-3 edge, so a book cycle always completes.
    always_comb begin
        state_nxt = state_q;
        if (armed) begin
            case (state_q)
                RUN:     if (phase_q == 2'd3 && halt) state_nxt = HALTED;
                HALTED:  if (!halt) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    assign run_active = armed && (state_q == RUN);
`else
    assign run_active = armed;
`endif

    // Phase and step sequencing; nothing moves until the first edge after reset.
    always_comb begin
        phase_nxt = phase_q;
        step_nxt  = step_q;
        if (run_active) begin
            phase_nxt = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                if (NSTEPS > 1) begin
                    step_nxt = {step_q[NSTEPS-2:0], step_q[NSTEPS-1]};
                end
            end
        end else if (armed) begin
            phase_nxt = 2'd0;
        end
    end

    // Counter registers; reset forces phase 0 and step 1 immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed   <= 1'b0;
            phase_q <= 2'd0;
            step_q  <= NSTEPS'(1);
        end else begin
            armed   <= 1'b1;
            phase_q <= phase_nxt;
            step_q  <= step_nxt;
        end
    end

    // Enable spans phases 0-2, set sits in phase 1 so it lies strictly inside enable.
    always_comb begin
        clke = run_active && (phase_q != 2'd3);
        clks = run_active && (phase_q == 2'd1);
        done = run_active && (phase_q == 2'd3) && step_q[NSTEPS-1];
    end

    assign step  = step_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_jstepper.sv
module tb_jstepper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt = 1'b0;

    logic clke6, clks6, done6; logic [1:0] phase6; logic [5:0] step6;
    logic clke2, clks2, done2; logic [1:0] phase2; logic [1:0] step2;
    logic clke8, clks8, done8; logic [1:0] phase8; logic [7:0] step8;

    int errors = 0;
    int checks = 0;
    int nst[3] = '{6, 2, 8};

    always #5 clk = ~clk;

    jstepper #(.NSTEPS(6)) u6 (.clk(clk), .reset(reset),
`ifdef JSTEPPER_HALT_EN
        .halt(halt),
`endif
        .clke(clke6), .clks(clks6), .step(step6), .phase(phase6), .done(done6));
    jstepper #(.NSTEPS(2)) u2 (.clk(clk), .reset(reset),
`ifdef JSTEPPER_HALT_EN
        .halt(halt),
`endif
        .clke(clke2), .clks(clks2), .step(step2), .phase(phase2), .done(done2));
    jstepper #(.NSTEPS(8)) u8 (.clk(clk), .reset(reset),
`ifdef JSTEPPER_HALT_EN
        .halt(halt),
`endif
        .clke(clke8), .clks(clks8), .step(step8), .phase(phase8), .done(done8));

    // Reference model: m_n counts running clocks since release; phase and
    // step follow from it by division, halted just stops the count.
    int m_n = 0;
    bit m_live = 0;
    bit m_halted = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_live = 0; m_halted = 0;
        end else if (!m_live) begin
            m_live = 1;
        end else if (m_halted) begin
            if (!halt) m_halted = 0;
        end else begin
`ifdef JSTEPPER_HALT_EN
            if (m_n % 4 == 3 && halt) m_halted = 1;
`endif
            m_n = m_n + 1;
        end
    end

    // Expected {clke, clks, done, phase, step zero-extended to 8}.
    function automatic logic [12:0] model(int n_steps);
        int ph, idx;
        logic [7:0] s;
        if (reset || !m_live) return {3'b000, 2'd0, 8'd1};
        ph  = m_n % 4;
        idx = (m_n / 4) % n_steps;
        s   = 8'(1 << idx);
        if (m_halted) return {3'b000, 2'd0, s};
        return {ph != 3, ph == 1, (ph == 3) && (idx == n_steps - 1), 2'(ph), s};
    endfunction

    function automatic logic [12:0] observe(int i);
        case (i)
            0:       return {clke6, clks6, done6, phase6, 8'(step6)};
            1:       return {clke2, clks2, done2, phase2, 8'(step2)};
            default: return {clke8, clks8, done8, phase8, step8};
        endcase
    endfunction

    task automatic test_reset();
        logic [12:0] o;
        reset = 1'b1; halt = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = observe(i);
            checks++;
            if (o !== 13'h0001) begin
                errors++;
                $display("FAIL reset N=%0d got %h want %h", nst[i], o, 13'h0001);
            end
        end
    endtask

    task automatic test_free_run();
        logic [12:0] o, e;
        int idx;
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            idx = ((k - 1) / 4) % 6;
            checks++;
            if (step6 !== 6'(1 << idx)) begin
                errors++;
                $display("FAIL free_run_step clk=%0d got %b want %b", k, step6, 6'(1 << idx));
            end
            checks++;
            if (done6 !== (k == 24)) begin
                errors++;
                $display("FAIL free_run_done clk=%0d got %b want %b", k, done6, (k == 24));
            end
            for (int i = 0; i < 3; i++) begin
                o = observe(i); e = model(nst[i]);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL free_run_model N=%0d clk=%0d got %h want %h", nst[i], k, o, e);
                end
            end
        end
    endtask

    task automatic test_phase_decode();
        bit pat_e[4] = '{1, 1, 1, 0};
        bit pat_s[4] = '{0, 1, 0, 0};
        int ph;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ph = m_n % 4;
            checks++;
            if (clke6 !== pat_e[ph] || clks6 !== pat_s[ph]) begin
                errors++;
                $display("FAIL decode ph=%0d got e=%b s=%b want e=%b s=%b", ph, clke6, clks6, pat_e[ph], pat_s[ph]);
            end
            checks++;
            if ((clks6 && !clke6) || (clks8 && !clke8) || (clks2 && !clke2)) begin
                errors++;
                $display("FAIL set_outside_enable got clks=1 clke=0 want nested");
            end
        end
    endtask

`ifdef JSTEPPER_HALT_EN
    task automatic test_halt();
        reset = 1'b1; halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (step6 !== 6'b000100 || phase6 !== 2'd1 || clks6 !== 1'b1) begin
            errors++;
            $display("FAIL halt_setup got step=%b phase=%0d clks=%b want 000100 1 1", step6, phase6, clks6);
        end
        halt = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (step6 !== 6'b000100 || phase6 !== 2'd3) begin
            errors++;
            $display("FAIL halt_completes got step=%b phase=%0d want 000100 3", step6, phase6);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({step6, phase6, clke6, clks6, done6} !== {6'b001000, 2'd0, 3'b000}) begin
                errors++;
                $display("FAIL halt_frozen cyc=%0d got step=%b phase=%0d e=%b s=%b d=%b want 001000 0 0 0 0",
                         k, step6, phase6, clke6, clks6, done6);
            end
        end
        halt = 1'b0;
        @(negedge clk);
        checks++;
        if ({step6, phase6, clke6, clks6} !== {6'b001000, 2'd0, 2'b10}) begin
            errors++;
            $display("FAIL halt_resume got step=%b phase=%0d e=%b s=%b want 001000 0 1 0", step6, phase6, clke6, clks6);
        end
        @(negedge clk);
        checks++;
        if (phase6 !== 2'd1 || clks6 !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume_set got phase=%0d clks=%b want 1 1", phase6, clks6);
        end
    endtask
`endif

    task automatic test_async_reset();
        reset = 1'b1; halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (18) @(negedge clk);
        checks++;
        if (step6 !== 6'b010000 || clks6 !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup got step=%b clks=%b want 010000 1", step6, clks6);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({clke6, clks6, done6, phase6, step6} !== {3'b000, 2'd0, 6'b000001}) begin
            errors++;
            $display("FAIL areset_immediate got e=%b s=%b step=%b phase=%0d want 0 0 000001 0", clke6, clks6, step6, phase6);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({clke6, clks6, phase6, step6} !== {2'b00, 2'd0, 6'b000001}) begin
                errors++;
                $display("FAIL areset_held got step=%b phase=%0d e=%b want 000001 0 0", step6, phase6, clke6);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (clke6 !== 1'b1 || phase6 !== 2'd0 || step6 !== 6'b000001) begin
            errors++;
            $display("FAIL areset_release got e=%b phase=%0d step=%b want 1 0 000001", clke6, phase6, step6);
        end
    endtask

    task automatic test_sweep();
        logic [12:0] o, e;
        reset = 1'b1; halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 9) begin
                checks++;
                if (step2 !== 2'b01) begin
                    errors++;
                    $display("FAIL wrap_n2 got %b want 01", step2);
                end
            end
            if (k == 33) begin
                checks++;
                if (step8 !== 8'h01) begin
                    errors++;
                    $display("FAIL wrap_n8 got %h want 01", step8);
                end
            end
        end
        for (int k = 0; k < 400; k++) begin
`ifdef JSTEPPER_HALT_EN
            halt = ($urandom_range(0, 3) == 0);
`endif
            reset = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            checks++;
            if (!$onehot(step6) || !$onehot(step2) || !$onehot(step8)) begin
                errors++;
                $display("FAIL onehot cyc=%0d got %b %b %b want one-hot", k, step6, step2, step8);
            end
            for (int i = 0; i < 3; i++) begin
                o = observe(i); e = model(nst[i]);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL sweep N=%0d cyc=%0d got %h want %h", nst[i], k, o, e);
                end
            end
        end
        reset = 1'b0; halt = 1'b0;
    endtask

    task automatic test_long_run();
        logic [12:0] o, e;
        reset = 1'b1; halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = observe(i); e = model(nst[i]);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL long_run N=%0d clk=%0d got %h want %h", nst[i], k, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_phase_decode();
`ifdef JSTEPPER_HALT_EN
        test_halt();
`endif
        test_async_reset();
        test_sweep();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jstepper.md
JSTEPPER -- requirements
Module: jstepper

Interface
- REQ-001 SHALL have parameter NSTEPS, default 6, meaning the number of instruction steps per cycle; the legal range is 2..8.
- REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port halt, input, 1 bit: freeze request, sampled at book-cycle boundaries (present only with JSTEPPER_HALT_EN).
- REQ-005 SHALL have port clke, output, 1 bit: register-enable window that drives the downstream we pins.
- REQ-006 SHALL have port clks, output, 1 bit: register-set pulse that drives the downstream ws pins.
- REQ-007 SHALL have port step, output, NSTEPS bits: the one-hot current step; bit 0 is step 1.
- REQ-008 SHALL have port phase, output, 2 bits: the current quarter of the book clock cycle.
- REQ-009 SHALL have port done, output, 1 bit: a single-clock pulse marking the end of the last step.

Function
- REQ-010 SHALL hold a 2-bit phase counter that increments by 1 on every rising edge in RUN and wraps 3 -> 0; one book cycle is 4 clk cycles.
- REQ-011 SHALL decode clke = 1 for phase 0, 1 and 2, and clke = 0 for phase 3 (the book clk OR clkd).
- REQ-012 SHALL decode clks = 1 only for phase 1 (the book clk AND clkd), so that set lies strictly inside enable.
- REQ-013 SHALL decode clke and clks combinationally from the phase and state registers only, with no other inputs in that path.
- REQ-014 SHALL rotate step left by one position on the edge where phase == 3; bit NSTEPS-1 wraps to bit 0.
- REQ-015 SHALL keep step exactly one-hot at all times outside reset; no zero or multi-hot value is ever visible.
- REQ-016 SHALL assert done when phase == 3 and step[NSTEPS-1] == 1 in RUN, and deassert it otherwise.
- REQ-017 SHALL have two states: RUN and HALTED.
- REQ-018 SHALL go RUN -> HALTED on the edge where phase == 3 and halt == 1; the step advance and phase wrap to 0 still occur on that edge.
- REQ-019 SHALL, in HALTED, hold phase at 0 and hold step, and force clke = 0, clks = 0 and done = 0.
- REQ-020 SHALL go HALTED -> RUN on the first edge with halt == 0; the first RUN cycle is phase 0 of the held step.
- REQ-021 SHALL give no effect to halt asserted at phase 0..2 until the next phase-3 edge; the current book cycle always completes.
- REQ-022 SHALL, with halt held high continuously from the phase-3 edge onward, produce no further set pulse.

Reset
- REQ-023 SHALL, while reset == 1, force phase = 0, step = bit 0 only, state = RUN, clke = 0, clks = 0 and done = 0, regardless of clk.
- REQ-024 SHALL, on reset asserted mid-cycle (any phase or step), return immediately to the reset values, with no partial clks pulse after assertion.
- REQ-025 SHALL, on the first rising edge after reset deasserts, present phase 0 decode (clke = 1) with step = 1.

Configuration
- REQ-026 SHALL, with JSTEPPER_HALT_EN defined, include the halt port, the HALTED state and REQ-018..REQ-022.
- REQ-027 SHALL, with JSTEPPER_HALT_EN undefined, omit the halt port and the HALTED state; the block is permanently RUN and all other requirements are unchanged.

Verification
- REQ-028 SHALL cover the free run: NSTEPS = 6, reset released, 24 clks -> step walks 000001 to 100000 with each value held 4 clks, then returns to 000001, and done pulses once on clk 24.
- REQ-029 SHALL cover the phase decode: any book cycle -> clke pattern 1,1,1,0 and clks pattern 0,1,0,0; clks is never 1 while clke is 0.
- REQ-030 SHALL cover a halt mid-cycle: halt = 1 at phase 1 of step 3 -> step 3 completes, step = 4 with phase 0 frozen, clke = clks = 0; halt = 0 -> step 4 resumes at phase 0.
- REQ-031 SHALL cover an asynchronous reset: reset pulsed mid-phase 1 of step 5 -> clks drops within the same cycle, then step = 000001 and phase = 0 until release.
- REQ-032 SHALL cover a parameter sweep: NSTEPS = 2 and NSTEPS = 8 -> wrap after 8 and 32 clks respectively, with the one-hot check passing every cycle.
- REQ-033 SHALL cover the macro off: build without JSTEPPER_HALT_EN, 100 clks -> identical to the free run, with no halt port present.
